// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg                                                               |
// | Shared types, constants and helpers for the 7-segment scan datapath.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package seg_pkg;

    typedef enum logic [0:0] {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Value is zero-extended to the widest supported display (8 digits).
    function automatic logic [3:0] nibble_sel(input logic [31:0] value, input logic [2:0] idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/segment_decoder_7bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | segment_decoder_7bit                                                  |
// | Hex nibble to active-low {a,b,c,d,e,f,g} segment pattern.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module segment_decoder_7bit
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            4'hF: seg = 7'h38;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_scan_ctrl                                                   |
// | Multiplexed scan of a common-anode display with blanking gaps and     |
// | frame-synchronous double-buffered updates.                            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module seven_seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000,
    parameter int GAP      = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  load,
    output logic                  pending,
    output logic [N_DIGITS-1:0]   anode_n,
    output logic [6:0]            seg,
    output logic                  frame_start
);

    localparam int TMAX = (DIV > GAP) ? DIV : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(N_DIGITS);

    localparam logic [0:0]    C_ST_GAP   = ST_GAP;
    localparam logic [0:0]    C_ST_SHOW  = ST_SHOW;
    localparam logic [TW-1:0] C_DIV_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] C_GAP_LAST = TW'(GAP - 1);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(N_DIGITS - 1);

    logic [0:0]            r_state;
    logic [TW-1:0]         r_timer;
    logic [IW-1:0]         r_idx;
    logic                  r_pending;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic [N_DIGITS-1:0]   r_shadow_blank;
    logic [4*N_DIGITS-1:0] r_display;
    logic [N_DIGITS-1:0]   r_display_blank;
    logic [N_DIGITS-1:0]   r_anode_n;
    logic [6:0]            r_seg;
    logic                  r_frame_start;

    logic                  w_timer_done;
    logic                  w_frame_edge;
    logic [3:0]            w_nibble;
    logic [6:0]            w_dec_seg;
    logic [N_DIGITS-1:0]   w_anode_n;
    logic [6:0]            w_seg;
    logic                  w_frame_start;

    assign w_timer_done = (r_state == C_ST_SHOW) ? (r_timer == C_DIV_LAST)
                                                 : (r_timer == C_GAP_LAST);
    // idx already points at the next digit while in GAP, so idx==0 marks the frame boundary.
    assign w_frame_edge = (r_state == C_ST_GAP) && w_timer_done && (r_idx == '0);

    assign w_nibble = nibble_sel(32'(r_display), 3'(r_idx));

    segment_decoder_7bit u_decoder (
        .nibble (w_nibble),
        .seg    (w_dec_seg)
    );

    always_comb begin
        w_anode_n     = '1;
        w_seg         = SEG_BLANK;
        w_frame_start = 1'b0;
        if (r_state == C_ST_SHOW) begin
            w_anode_n[r_idx] = 1'b0;
            if (!r_display_blank[r_idx]) begin
                w_seg = w_dec_seg;
            end
            w_frame_start = (r_idx == '0) && (r_timer == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= C_ST_GAP;
            r_timer         <= '0;
            r_idx           <= '0;
            r_pending       <= 1'b0;
            r_shadow        <= '0;
            r_shadow_blank  <= '0;
            r_display       <= '0;
            r_display_blank <= '1;
            r_anode_n       <= '1;
            r_seg           <= SEG_BLANK;
            r_frame_start   <= 1'b0;
        end else begin
            r_anode_n     <= w_anode_n;
            r_seg         <= w_seg;
            r_frame_start <= w_frame_start;

            if (w_timer_done) begin
                r_timer <= '0;
                if (r_state == C_ST_SHOW) begin
                    r_state <= C_ST_GAP;
                    r_idx   <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IW'(1);
                end else begin
                    r_state <= C_ST_SHOW;
                end
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_frame_edge && r_pending) begin
                r_display       <= r_shadow;
                r_display_blank <= r_shadow_blank;
            end

            // A load coinciding with a commit stays pending for the following frame.
            if (load) begin
                r_shadow       <= value;
                r_shadow_blank <= blank;
                r_pending      <= 1'b1;
            end else if (w_frame_edge) begin
                r_pending      <= 1'b0;
            end
        end
    end

    assign pending     = r_pending;
    assign anode_n     = r_anode_n;
    assign seg         = r_seg;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seven_seg_scan_ctrl                                                |
// | Scoreboard bench: frame-level model queues expected digits.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_seven_seg_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int GAP = 1;
    localparam int P   = N * (DIV + GAP);

    logic          clk = 1'b0;
    logic          reset;
    logic [4*N-1:0] value;
    logic [N-1:0]  blank;
    logic          load;
    logic          pending;
    logic [N-1:0]  anode_n;
    logic [6:0]    seg;
    logic          frame_start;

    seven_seg_scan_ctrl #(.N_DIGITS(N), .DIV(DIV), .GAP(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .blank       (blank),
        .load        (load),
        .pending     (pending),
        .anode_n     (anode_n),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         d;
        logic [3:0] an;
        logic [6:0] sg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: edges since reset release; commits land every P edges starting at edge GAP.
    int             model_n;
    logic           m_pending;
    logic [4*N-1:0] m_shadow, m_disp;
    logic [N-1:0]   m_shblank, m_dblank;

    always @(posedge clk) begin
        if (reset) begin
            model_n   = 0;
            m_pending = 1'b0;
            m_shadow  = '0;
            m_shblank = '0;
            m_disp    = '0;
            m_dblank  = '1;
            exp_q.delete();
        end else begin
            model_n++;
            if (model_n >= GAP && (model_n - GAP) % P == 0) begin
                if (m_pending) begin
                    m_disp    = m_shadow;
                    m_dblank  = m_shblank;
                    m_pending = 1'b0;
                end
                for (int d = 0; d < N; d++) begin
                    exp_t e;
                    e.d  = d;
                    e.an = ~(4'(1) << d);
                    e.sg = m_dblank[d] ? 7'h7F : seg_tab[m_disp[4*d +: 4]];
                    exp_q.push_back(e);
                end
            end
            if (load) begin
                m_shadow  = value;
                m_shblank = blank;
                m_pending = 1'b1;
            end
        end
    end

    // Monitor: a digit run begins whenever an anode goes low after a dark cycle.
    bit   prev_lit   = 1'b0;
    bit   first_gap  = 1'b1;
    int   lit_cnt    = 0;
    int   gap_cnt    = 0;
    exp_t cur;

    always @(posedge clk) begin
        #1;
        check("pending", pending, m_pending);
        if (reset) begin
            check("reset_anode", anode_n, 4'hF);
            check("reset_seg", seg, 7'h7F);
            check("reset_frame_start", frame_start, 1'b0);
            prev_lit  = 1'b0;
            first_gap = 1'b1;
            gap_cnt   = 1;
        end else if (anode_n != 4'hF) begin
            if (!prev_lit) begin
                check("gap_len", gap_cnt, first_gap ? GAP + 1 : GAP);
                first_gap = 1'b0;
                if (exp_q.size() == 0) begin
                    check("queue_nonempty", 0, 1);
                    cur.d  = -1;
                    cur.an = 4'hF;
                    cur.sg = 7'h7F;
                end else begin
                    cur = exp_q.pop_front();
                end
                check("frame_start_d0", frame_start, cur.d == 0);
                lit_cnt = 1;
            end else begin
                check("frame_start_mid", frame_start, 1'b0);
                lit_cnt++;
            end
            check("anode", anode_n, cur.an);
            check("seg", seg, cur.sg);
            prev_lit = 1'b1;
        end else begin
            check("dark_seg", seg, 7'h7F);
            check("dark_frame_start", frame_start, 1'b0);
            if (prev_lit) begin
                check("show_len", lit_cnt, DIV);
                gap_cnt = 1;
            end else begin
                gap_cnt++;
            end
            prev_lit = 1'b0;
        end
    end

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] b);
        value = v;
        blank = b;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Returns at the negedge just before a commit edge.
    task automatic wait_commit();
        for (int i = 0; i < 2 * P; i++) begin
            if ((model_n + 1 - GAP) % P == 0) return;
            @(negedge clk);
        end
        check("wait_commit_timeout", 0, 1);
    endtask

    task automatic wait_anode(input logic [N-1:0] pat);
        for (int i = 0; i < 2 * P; i++) begin
            if (anode_n == pat) return;
            @(negedge clk);
        end
        check("wait_anode_timeout", anode_n, pat);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = '0;
        blank = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * P) @(negedge clk);

        repeat (7) @(negedge clk);
        do_load(16'h1234, 4'b0000);
        repeat (2 * P) @(negedge clk);

        wait_commit();
        repeat (3) @(negedge clk);
        do_load(16'hAAAA, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'hBEEF, 4'b0000);
        repeat (2 * P) @(negedge clk);

        wait_commit();
        repeat (3) @(negedge clk);
        do_load(16'h5678, 4'b0000);
        wait_commit();
        do_load(16'h9ABC, 4'b0000);
        repeat (2 * P) @(negedge clk);

        do_load(16'h0008, 4'b1110);
        repeat (2 * P) @(negedge clk);

        repeat (12) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            do_load(16'($urandom), 4'($urandom));
        end
        repeat (2 * P) @(negedge clk);

        wait_anode(4'b1101);
        do_load(16'hFFFF, 4'b0000);
        wait_anode(4'b1011);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * P) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
